// File: rtl/addsub_result_stage.sv
// Registered result stage behind the 4-bit adder/subtractor: derives status flags,
// buffers results in a small FIFO and presents them on a valid/ready handshake.
module addsub_result_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_op,
    output logic             out_carry,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic             ovf_sticky,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    // Entry layout: {result, op, carry, borrow, ovf, zero, neg}
    localparam int unsigned EW    = WIDTH + 6;

    localparam logic [CW-1:0]    CNT_ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE_C  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL_C = CW'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
    localparam logic [CNT_W-1:0] OPC_ONE_C  = CNT_W'(1);

    // Builds a FIFO entry from the adder's inputs and outputs; the sum is never recomputed.
    function automatic logic [EW-1:0] make_entry(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb,
        input logic             fsel,
        input logic [WIDTH-1:0] fsum,
        input logic             fcout
    );
        logic f_borrow;
        logic f_ovf;
        logic f_zero;
        logic f_neg;
        f_borrow = fsel & ~fcout;
        f_ovf    = (fa[WIDTH-1] ^ fsum[WIDTH-1]) & ~(fa[WIDTH-1] ^ fb[WIDTH-1] ^ fsel);
        f_zero   = (fsum == {WIDTH{1'b0}});
        f_neg    = fsum[WIDTH-1];
        return {fsum, fsel, fcout, f_borrow, f_ovf, f_zero, f_neg};
    endfunction

    logic [EW-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             valid_r;
    logic             not_full_r;
    logic             ovf_sticky_r;
    logic [CNT_W-1:0] op_count_r;

    logic             push_s;
    logic             pop_s;
    logic [CW-1:0]    count_nxt_s;
    logic [EW-1:0]    entry_s;
    logic             entry_ovf_s;
    logic [EW-1:0]    head_s;

    // Handshake qualifiers; in_ready depends only on registered state and reset.
    always_comb begin
        in_ready = rst_n & not_full_r;
        push_s   = in_valid & in_ready;
        pop_s    = valid_r & out_ready;
    end

    // Entry formed only when a push happens, so idle data inputs never reach state.
    always_comb begin
        entry_s = {EW{1'b0}};
        if (push_s) begin
            entry_s = make_entry(a, b, select, sum, cout);
        end else begin
            entry_s = {EW{1'b0}};
        end
        entry_ovf_s = entry_s[2];
    end

    // Occupancy update; push+pop together leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and the registered full/empty status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= CNT_ZERO_C;
            valid_r    <= 1'b0;
            not_full_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != CNT_ZERO_C);
            not_full_r <= (count_nxt_s != CNT_FULL_C);
        end
    end

    // Sticky overflow: a same-cycle overflowing push wins over clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (push_s && entry_ovf_s) begin
            ovf_sticky_r <= 1'b1;
        end else if (sticky_clr) begin
            ovf_sticky_r <= 1'b0;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

    // Completed-operation counter, wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            op_count_r <= op_count_r + OPC_ONE_C;
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign head_s     = mem_r[rd_ptr_r];
    assign out_valid  = valid_r;
    assign out_result = head_s[EW-1:6];
    assign out_op     = head_s[5];
    assign out_carry  = head_s[4];
    assign out_borrow = head_s[3];
    assign out_ovf    = head_s[2];
    assign out_zero   = head_s[1];
    assign out_neg    = head_s[0];
    assign ovf_sticky = ovf_sticky_r;
    assign op_count   = op_count_r;

endmodule
